// File: rtl/acc_acb_pkg.sv
// rtl/acc_acb_pkg.sv - shared ACB request/response widths, commands and field positions
package acc_acb_pkg;

  localparam int ACB_REQ_W  = 110;
  localparam int ACB_RESP_W = 65;

  localparam logic [1:0] ACB_CMD_READ  = 2'b01;
  localparam logic [1:0] ACB_CMD_WRITE = 2'b00;

  localparam int ACB_CMD_MSB   = 109;
  localparam int ACB_CMD_LSB   = 108;
  localparam int ACB_MASK_MSB  = 107;
  localparam int ACB_MASK_LSB  = 100;
  localparam int ACB_ADDR_MSB  = 99;
  localparam int ACB_ADDR_LSB  = 64;
  localparam int ACB_WDATA_MSB = 63;
  localparam int ACB_WDATA_LSB = 0;
  localparam int ACB_RESP_ERR  = 64;

  // Requester identity as stored in the owner FIFO and the round-robin pointer
  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_WB    = 1'b1
  } acb_req_id_e;

endpackage

// File: rtl/acb_mem_arbiter_if.sv
// rtl/acb_mem_arbiter_if.sv - requester, memory-pipe and status signals of the ACB arbiter
interface acb_mem_arbiter_if #(
  parameter int MAX_OUTSTANDING = 4
);
  import acc_acb_pkg::*;

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic                  req0_valid;
  logic                  req0_ready;
  logic [ACB_REQ_W-1:0]  req0_data;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [ACB_REQ_W-1:0]  req1_data;

  logic                  resp0_valid;
  logic                  resp0_ready;
  logic [ACB_RESP_W-1:0] resp0_data;
  logic                  resp1_valid;
  logic                  resp1_ready;
  logic [ACB_RESP_W-1:0] resp1_data;

  logic [ACB_REQ_W-1:0]  ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data;
  logic                  ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack;
  logic                  ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req;
  logic [ACB_RESP_W-1:0] ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data;
  logic                  ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req;
  logic                  ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack;

  logic [CNT_W-1:0]      outstanding;
  logic                  busy;
  logic                  err_unexpected_resp;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_data, resp1_valid, resp1_data,
    input  resp0_ready, resp1_ready,
    output ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data, ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack,
    input  ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req,
    input  ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data, ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req,
    output ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack,
    output outstanding, busy, err_unexpected_resp
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_data, resp1_valid, resp1_data,
    output resp0_ready, resp1_ready,
    input  ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data, ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack,
    output ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req,
    output ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data, ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req,
    input  ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack,
    input  outstanding, busy, err_unexpected_resp
  );

endinterface

// File: rtl/acb_owner_fifo.sv
// rtl/acb_owner_fifo.sv - 1-bit in-order owner FIFO recording which requester each request came from
module acb_owner_fifo #(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             push_id,
  input  logic             pop,
  output logic             head_id,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head_id = mem_q[rd_ptr_q];

  // Pointer/count update; pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/acb_mem_arbiter.sv
// rtl/acb_mem_arbiter.sv - round-robin two-requester arbiter for the shared ACB memory port
module acb_mem_arbiter
  import acc_acb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic               clk,
  input  logic               reset,
  acb_mem_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  acb_req_id_e           prio_q, prio_d;
  logic                  ack_q, ack_d;
  logic [ACB_REQ_W-1:0]  slot_q, slot_d;
  logic                  err_q, err_d;

  logic                  slot_drain, can_accept, grant0, grant1, accept;
  logic                  resp_hit, write_ack, fifo_pop;
  logic                  fifo_head, fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;

  acb_owner_fifo #(.DEPTH(MAX_OUTSTANDING)) u_owner_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (accept),
    .push_id (grant1),
    .pop     (fifo_pop),
    .head_id (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Grant: the slot must be free or leaving this cycle, and the owner FIFO must have room.
  // Full is taken from the registered count so a same-cycle pop never reaches reqN_ready.
  always_comb begin
    slot_drain = ack_q && bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req;
    can_accept = (!ack_q || slot_drain) && !fifo_full;
    grant0     = can_accept && bus.req0_valid && (!bus.req1_valid || prio_q == REQ_FETCH);
    grant1     = can_accept && bus.req1_valid && (!bus.req0_valid || prio_q == REQ_WB);
    accept     = grant0 || grant1;
  end

  // Next-state for slot, round-robin pointer and sticky error
  always_comb begin
    prio_d = prio_q;
    ack_d  = ack_q;
    slot_d = slot_q;
    if (accept) begin
      ack_d  = 1'b1;
      slot_d = grant1 ? bus.req1_data : bus.req0_data;
      prio_d = grant1 ? REQ_FETCH : REQ_WB;
    end else if (slot_drain) begin
      ack_d  = 1'b0;
      slot_d = '0;
    end
    err_d = err_q || (bus.ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req && fifo_empty);
  end

  // Response routing straight from the FIFO head; stray responses are acked and dropped
  always_comb begin
    resp_hit  = bus.ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req && !fifo_empty;
    write_ack = fifo_empty || ((fifo_head == REQ_WB) ? bus.resp1_ready : bus.resp0_ready);
    fifo_pop  = resp_hit && write_ack;
  end

  // Arbiter state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q <= REQ_FETCH;
      ack_q  <= 1'b0;
      slot_q <= '0;
      err_q  <= 1'b0;
    end else begin
      prio_q <= prio_d;
      ack_q  <= ack_d;
      slot_q <= slot_d;
      err_q  <= err_d;
    end
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.resp0_valid = resp_hit && (fifo_head == REQ_FETCH);
  assign bus.resp1_valid = resp_hit && (fifo_head == REQ_WB);
  assign bus.resp0_data  = bus.ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data;
  assign bus.resp1_data  = bus.ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data;

  assign bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data  = slot_q;
  assign bus.ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack   = ack_q;
  assign bus.ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack = write_ack;

  assign bus.outstanding         = fifo_count;
  assign bus.busy                = (fifo_count != '0);
  assign bus.err_unexpected_resp = err_q;

endmodule
